// File: rtl/cgra_route_pkg.sv
// Shared types and coordinate helpers for the XY path router.
// Edge fields are sized for meshes up to 256 cells; narrower ports zero-extend into them.
package cgra_route_pkg;

    localparam int IDX_MAX_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ROUTE,
        ROLLBACK,
        EMIT,
        DONE
    } state_t;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] src;
        logic [IDX_MAX_W-1:0] dst;
    } edge_t;

    typedef struct packed {
        logic valid;
        logic ok;
    } result_t;

    function automatic int idx_to_x(input int idx, input int grid_w);
        return idx % grid_w;
    endfunction

    function automatic int idx_to_y(input int idx, input int grid_w);
        return idx / grid_w;
    endfunction

endpackage

// File: rtl/cgra_xy_path_router_if.sv
// Edge-load and result handshake bundle between placement controller and router.
interface cgra_xy_path_router_if #(
    parameter int IDX_W  = 4,
    parameter int EIDX_W = 4
);
    logic              edge_in_valid;
    logic              edge_in_ready;
    logic [IDX_W-1:0]  edge_in_src;
    logic [IDX_W-1:0]  edge_in_dst;
    logic              res_valid;
    logic              res_ready;
    logic [EIDX_W-1:0] res_edge_idx;
    logic              res_ok;
    logic [IDX_W-1:0]  res_hops;

    modport master (
        output edge_in_valid, edge_in_src, edge_in_dst, res_ready,
        input  edge_in_ready, res_valid, res_edge_idx, res_ok, res_hops
    );

    modport slave (
        input  edge_in_valid, edge_in_src, edge_in_dst, res_ready,
        output edge_in_ready, res_valid, res_edge_idx, res_ok, res_hops
    );
endinterface

// File: rtl/cgra_path_stack.sv
// LIFO of cells reserved by the edge currently being routed, so a failure can undo them.
module cgra_path_stack #(
    parameter  int DEPTH = 8,
    parameter  int W     = 4,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    push_data,
    output logic [W-1:0]    top,
    output logic [SP_W-1:0] sp,
    output logic            empty
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     sp <= '0;
        else if (clear) sp <= '0;
        else if (push)  sp <= sp + SP_W'(1);
        else if (pop)   sp <= sp - SP_W'(1);
    end

    // NOTE: storage is not reset; only the pointer decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[AW'(sp)] <= push_data;
    end

    assign top   = mem[AW'(sp - SP_W'(1))];
    assign empty = (sp == '0);

endmodule

// File: rtl/cgra_xy_path_router.sv
// Greedy X-then-Y router for a list of DFG edges over a GRID_W x GRID_H mesh,
// with per-edge rollback of reserved cells and a live occupancy map.
module cgra_xy_path_router
    import cgra_route_pkg::*;
#(
    parameter  int GRID_W    = 4,
    parameter  int GRID_H    = 4,
    parameter  int MAX_EDGES = 16,
    localparam int CELLS     = GRID_W * GRID_H,
    localparam int IDX_W     = $clog2(CELLS),
    localparam int STK_DEPTH = GRID_W + GRID_H,
    localparam int EIDX_W    = $clog2(MAX_EDGES),
    localparam int CNT_W     = $clog2(MAX_EDGES + 1),
    localparam int SP_W      = $clog2(STK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_clear,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CELLS-1:0] occ_map,
    cgra_xy_path_router_if.slave bus
);

    state_t            state;
    logic [CNT_W-1:0]  count, e, cnt_next;
    edge_t             slots [MAX_EDGES];
    edge_t             fetch_edge;
    logic [IDX_W-1:0]  cur, dst, hops;
    result_t           res;

    logic              wr_en;
    int                cur_x, cur_y, dst_x, dst_y;
    logic [IDX_W-1:0]  nx, ny, step_idx;
    logic              x_ok, y_ok, at_dst, step, stk_push, stk_pop, stk_clear;
    logic [IDX_W-1:0]  stk_top;
    logic [SP_W-1:0]   stk_sp;
    logic              stk_empty;

    assign bus.edge_in_ready = (state == IDLE) && (count < CNT_W'(MAX_EDGES));
    assign bus.res_valid     = res.valid;
    assign bus.res_ok        = res.ok;
    assign bus.res_hops      = hops;
    assign bus.res_edge_idx  = e[EIDX_W-1:0];
    assign fetch_edge        = slots[e[EIDX_W-1:0]];

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        wr_en     = (state == IDLE) && !cfg_clear && bus.edge_in_valid && bus.edge_in_ready;
        cnt_next  = count + CNT_W'(wr_en);
        cur_x     = idx_to_x(int'(cur), GRID_W);
        cur_y     = idx_to_y(int'(cur), GRID_W);
        dst_x     = idx_to_x(int'(dst), GRID_W);
        dst_y     = idx_to_y(int'(dst), GRID_W);
        nx        = (dst_x > cur_x) ? cur + IDX_W'(1) : cur - IDX_W'(1);
        ny        = (dst_y > cur_y) ? cur + IDX_W'(GRID_W) : cur - IDX_W'(GRID_W);
        // The destination counts as free even if another path already passes through it.
        x_ok      = (dst_x != cur_x) && (!occ_map[nx] || nx == dst);
        y_ok      = (dst_y != cur_y) && (!occ_map[ny] || ny == dst);
        at_dst    = (cur == dst);
        step      = (state == ROUTE) && !at_dst && (x_ok || y_ok);
        step_idx  = x_ok ? nx : ny;
        stk_push  = step && (step_idx != dst) && (stk_sp < SP_W'(STK_DEPTH));
        stk_pop   = (state == ROLLBACK) && !stk_empty;
        stk_clear = (state == FETCH);
    end

    always_ff @(posedge clk) begin
        if (wr_en) slots[count[EIDX_W-1:0]] <= '{src: IDX_MAX_W'(bus.edge_in_src),
                                                 dst: IDX_MAX_W'(bus.edge_in_dst)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            e       <= '0;
            occ_map <= '0;
            cur     <= '0;
            dst     <= '0;
            hops    <= '0;
            res     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_clear) begin
                        occ_map <= '0;
                        count   <= '0;
                        e       <= '0;
                    end else begin
                        count <= cnt_next;
                        // Routing resumes at the first edge not yet routed, so batches append.
                        if (start) begin
                            if (e == cnt_next) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= FETCH;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                FETCH: begin
                    cur  <= fetch_edge.src[IDX_W-1:0];
                    dst  <= fetch_edge.dst[IDX_W-1:0];
                    hops <= '0;
                    res  <= '0;
                    if (fetch_edge.src >= IDX_MAX_W'(CELLS) || fetch_edge.dst >= IDX_MAX_W'(CELLS)) begin
                        res.valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        state <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (at_dst) begin
                        res   <= '{valid: 1'b1, ok: 1'b1};
                        state <= EMIT;
                    end else if (step) begin
                        cur  <= step_idx;
                        hops <= hops + IDX_W'(1);
                        if (stk_push) occ_map[step_idx] <= 1'b1;
                    end else begin
                        state <= ROLLBACK;
                    end
                end
                ROLLBACK: begin
                    if (stk_empty) begin
                        res.valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        occ_map[stk_top] <= 1'b0;
                    end
                end
                EMIT: begin
                    if (bus.res_ready) begin
                        res.valid <= 1'b0;
                        e         <= e + CNT_W'(1);
                        if (e + CNT_W'(1) == count) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    cgra_path_stack #(
        .DEPTH (STK_DEPTH),
        .W     (IDX_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (step_idx),
        .top       (stk_top),
        .sp        (stk_sp),
        .empty     (stk_empty)
    );

endmodule

// File: tb/tb_cgra_xy_path_router.sv
// Directed bench for the 4x4 XY path router with hand-computed routes and occupancy maps.
module tb_cgra_xy_path_router;

    localparam int GRID_W    = 4;
    localparam int GRID_H    = 4;
    localparam int MAX_EDGES = 16;
    localparam int CELLS     = 16;
    localparam int IDX_W     = 4;
    localparam int EIDX_W    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_clear = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [CELLS-1:0] occ_map;

    int n_vec  = 0;
    int n_miss = 0;

    cgra_xy_path_router_if #(.IDX_W(IDX_W), .EIDX_W(EIDX_W)) bus ();

    cgra_xy_path_router #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .MAX_EDGES (MAX_EDGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_clear (cfg_clear),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .occ_map   (occ_map),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic apply_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_edge(input int src, input int dst);
        bus.edge_in_valid = 1'b1;
        bus.edge_in_src   = IDX_W'(src);
        bus.edge_in_dst   = IDX_W'(dst);
        @(negedge clk);
        bus.edge_in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic exp_ok, input int exp_hops,
                              input int exp_idx, input logic [15:0] exp_occ, input int hold,
                              output logic done_seen, output logic busy_seen);
        int n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            done_seen = 1'b0;
            busy_seen = 1'b1;
            return;
        end
        check({tag, "_ok"},   32'(bus.res_ok),       32'(exp_ok));
        check({tag, "_hops"}, 32'(bus.res_hops),     32'(exp_hops));
        check({tag, "_idx"},  32'(bus.res_edge_idx), 32'(exp_idx));
        check({tag, "_occ"},  32'(occ_map),          32'(exp_occ));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.res_valid),    32'd1);
            check({tag, "_hold_ok"},    32'(bus.res_ok),       32'(exp_ok));
            check({tag, "_hold_hops"},  32'(bus.res_hops),     32'(exp_hops));
            check({tag, "_hold_idx"},   32'(bus.res_edge_idx), 32'(exp_idx));
            check({tag, "_hold_done"},  32'(done),             32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        done_seen = done;
        busy_seen = busy;
    endtask

    initial begin
        logic d, b;
        bus.edge_in_valid = 1'b0;
        bus.edge_in_src   = '0;
        bus.edge_in_dst   = '0;
        bus.res_ready     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_busy",  32'(busy),              32'd0);
        check("rst_done",  32'(done),              32'd0);
        check("rst_valid", 32'(bus.res_valid),     32'd0);
        check("rst_occ",   32'(occ_map),           32'd0);
        check("rst_ready", 32'(bus.edge_in_ready), 32'd1);

        // Empty list: start goes straight to a done pulse.
        do_start();
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // 0->3 along row 0: cells 1,2 reserved.
        load_edge(0, 3);
        do_start();
        check("t1_busy", 32'(busy), 32'd1);
        get_result("t1", 1'b1, 3, 0, 16'h0006, 0, d, b);
        check("t1_done", 32'(d), 32'd1);
        check("t1_busy_low", 32'(b), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // 0->2 appended: cell 1 blocked and dy = 0, immediate fail.
        load_edge(0, 2);
        do_start();
        get_result("t2", 1'b0, 0, 1, 16'h0006, 0, d, b);
        check("t2_done", 32'(d), 32'd1);
        @(negedge clk);

        // cfg_clear wins over a same-cycle edge write.
        cfg_clear         = 1'b1;
        bus.edge_in_valid = 1'b1;
        bus.edge_in_src   = 4'd0;
        bus.edge_in_dst   = 4'd3;
        @(negedge clk);
        cfg_clear         = 1'b0;
        bus.edge_in_valid = 1'b0;
        check("clr_occ", 32'(occ_map), 32'd0);
        do_start();
        check("clr_empty_done", 32'(done), 32'd1);

        // 4->7 then 0->10: second edge blocked at 6 after two hops, rolls back.
        apply_reset();
        load_edge(4, 7);
        load_edge(0, 10);
        do_start();
        get_result("t3e0", 1'b1, 3, 0, 16'h0060, 0, d, b);
        check("t3e0_no_done", 32'(d), 32'd0);
        get_result("t3e1", 1'b0, 2, 1, 16'h0060, 0, d, b);
        check("t3e1_done", 32'(d), 32'd1);
        check("t3_occ_after", 32'(occ_map), 32'h0060);
        @(negedge clk);

        // 15->0 with the consumer stalling five cycles.
        apply_reset();
        load_edge(15, 0);
        do_start();
        get_result("t4", 1'b1, 6, 0, 16'h7110, 5, d, b);
        check("t4_done", 32'(d), 32'd1);
        check("t4_busy_low", 32'(b), 32'd0);
        @(negedge clk);

        // Reset in the middle of routing 15->0 (after the first step into 14).
        apply_reset();
        load_edge(15, 0);
        do_start();
        repeat (2) @(negedge clk);
        check("t5_busy_mid", 32'(busy),    32'd1);
        check("t5_occ_mid",  32'(occ_map), 32'h4000);
        reset = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy),          32'd0);
        check("t5_rst_occ",   32'(occ_map),       32'd0);
        check("t5_rst_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_ready", 32'(bus.edge_in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
